t03_nes_pad_poller: RTL and testbench

Parametrised serial game-pad poller for NUM_PADS NES/SNES-style controllers sharing one latch line and one clock line. It generates latch/clock waveforms from a cycle divider and deserialises each pad's active-low data line. It publishes inverted (active-high) button words, per-poll rising-edge "pressed" flags and a one-cycle valid strobe. It replaces the fixed two-pad, 8-bit front end and feeds the player FSMs and the packed game-input bus.

---
 rtl/t03_pad_pkg.sv | 23 ++
 rtl/t03_pad_shift_channel.sv | 38 +++
 rtl/t03_nes_pad_poller.sv | 83 ++++++++
 tb/tb_t03_nes_pad_poller.sv | 229 ++++++++++++++++++++++
 4 files changed

// File: rtl/t03_pad_pkg.sv
// t03_pad_pkg: shared FSM states, button bit positions and width helper for the pad poller
package t03_pad_pkg;

    typedef enum logic [2:0] {IDLE, LATCH, CLK_HI, CLK_LO, DONE} state_t;

    localparam int BTN_A      = 0;
    localparam int BTN_B      = 1;
    localparam int BTN_SELECT = 2;
    localparam int BTN_START  = 3;
    localparam int BTN_UP     = 4;
    localparam int BTN_DOWN   = 5;
    localparam int BTN_LEFT   = 6;
    localparam int BTN_RIGHT  = 7;
    localparam int BTN_SNES_A = 8;
    localparam int BTN_SNES_X = 9;
    localparam int BTN_SNES_L = 10;
    localparam int BTN_SNES_R = 11;

    function automatic int idx_w(input int n);
        return n > 1 ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/t03_pad_shift_channel.sv
// t03_pad_shift_channel: one pad's synchroniser, bit capture and button/pressed output registers
module t03_pad_shift_channel
    import t03_pad_pkg::*;
#(
    parameter int BITS_PER_PAD = 8,
    parameter int IW = idx_w(BITS_PER_PAD)
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    data,
    input  logic                    sample_en,
    input  logic [IW-1:0]           bit_idx,
    input  logic                    commit,
    output logic [BITS_PER_PAD-1:0] buttons,
    output logic [BITS_PER_PAD-1:0] pressed
);

    logic [1:0]              sync;
    logic [BITS_PER_PAD-1:0] shift;

    // synchronise the line, store inverted samples, publish on commit
    always_ff @(posedge clk) begin
        if (rst) begin
            sync    <= 2'b11;
            shift   <= '0;
            buttons <= '0;
            pressed <= '0;
        end else begin
            sync <= {sync[0], data};
            if (sample_en) shift[bit_idx] <= ~sync[1];
            if (commit) begin
                buttons <= shift;
                pressed <= shift & ~buttons;
            end
        end
    end

endmodule

// File: rtl/t03_nes_pad_poller.sv
// t03_nes_pad_poller: latch/clock sequencer and NUM_PADS deserialisers for NES/SNES pads
module t03_nes_pad_poller
    import t03_pad_pkg::*;
#(
    parameter int NUM_PADS     = 2,
    parameter int BITS_PER_PAD = 8,
    parameter int CLK_DIV      = 60,
    parameter int POLL_PERIOD  = 166667
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             auto_poll,
    input  logic                             poll_req,
    input  logic [NUM_PADS-1:0]              pad_data,
    output logic                             pad_latch,
    output logic                             pad_clk,
    output logic                             busy,
    output logic [NUM_PADS*BITS_PER_PAD-1:0] buttons,
    output logic [NUM_PADS*BITS_PER_PAD-1:0] pressed,
    output logic                             sample_valid
);

    localparam int DW = idx_w(2 * CLK_DIV);
    localparam int IW = idx_w(BITS_PER_PAD);
    localparam int PW = idx_w(POLL_PERIOD);

    state_t        state, next;
    logic [DW-1:0] div;
    logic [IW-1:0] idx;
    logic [PW-1:0] per;
    logic          div_last, sample_en, start, per_sat;

    assign div_last     = div == DW'(state == LATCH ? 2 * CLK_DIV - 1 : CLK_DIV - 1);
    assign sample_en    = div_last && (state == LATCH || state == CLK_LO);
    assign per_sat      = per == PW'(POLL_PERIOD - 1);
    assign start        = state == IDLE && next == LATCH;
    assign pad_latch    = state == LATCH;
    assign pad_clk      = state == CLK_HI;
    assign busy         = state != IDLE;
    assign sample_valid = state == DONE;

    // next-state logic; each timed state leaves on the last cycle of its divider
    always_comb begin
        next = state;
        case (state)
            IDLE:    next = (poll_req || (auto_poll && per_sat)) ? LATCH : IDLE;
            LATCH:   next = div_last ? CLK_HI : LATCH;
            CLK_HI:  next = div_last ? CLK_LO : CLK_HI;
            CLK_LO:  next = !div_last ? CLK_LO : idx == IW'(BITS_PER_PAD - 1) ? DONE : CLK_HI;
            DONE:    next = IDLE;
            default: next = IDLE;
        endcase
    end

    // state, per-state divider, bit index and saturating poll-period counter
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            div   <= '0;
            idx   <= '0;
            per   <= '0;
        end else begin
            state <= next;
            div   <= next != state ? '0 : div + 1'b1;
            idx   <= state == IDLE ? '0 : sample_en ? idx + 1'b1 : idx;
            per   <= start ? '0 : per_sat ? per : per + 1'b1;
        end
    end

    for (genvar p = 0; p < NUM_PADS; p++) begin : g_pad
        t03_pad_shift_channel #(.BITS_PER_PAD(BITS_PER_PAD)) u_chan (
            .clk      (clk),
            .rst      (rst),
            .data     (pad_data[p]),
            .sample_en(sample_en),
            .bit_idx  (idx),
            .commit   (state == DONE),
            .buttons  (buttons[p*BITS_PER_PAD +: BITS_PER_PAD]),
            .pressed  (pressed[p*BITS_PER_PAD +: BITS_PER_PAD])
        );
    end

endmodule

// File: tb/tb_t03_nes_pad_poller.sv
// tb_t03_nes_pad_poller: randomized scenario bench with behavioural pad models for NES and SNES configs
module tb_t03_nes_pad_poller;

    logic        clk = 0;
    logic        rst = 1;
    logic        auto_poll = 0, poll_req = 0;
    logic [1:0]  pad_data;
    logic        pad_latch, pad_clk, busy, sample_valid;
    logic [15:0] buttons, pressed;

    logic        auto_poll16 = 0, poll_req16 = 0;
    logic [0:0]  pad_data16;
    logic        pad_latch16, pad_clk16, busy16, sample_valid16;
    logic [15:0] buttons16, pressed16;

    int checks = 0, errors = 0;

    logic [1:0][7:0] btn = '0;
    logic [1:0]      glitch = '0;
    int              cnt = 99;
    logic [15:0]     btn16 = '0;
    int              cnt16 = 99;
    logic [15:0]     exp_prev = '0;

    int m_latch, m_pulses, m_badlen, m_busy, m_sv, m_sv_at;
    bit m_to;

    t03_nes_pad_poller #(.NUM_PADS(2), .BITS_PER_PAD(8), .CLK_DIV(4), .POLL_PERIOD(100)) dut (
        .clk(clk), .rst(rst), .auto_poll(auto_poll), .poll_req(poll_req), .pad_data(pad_data),
        .pad_latch(pad_latch), .pad_clk(pad_clk), .busy(busy), .buttons(buttons),
        .pressed(pressed), .sample_valid(sample_valid)
    );

    t03_nes_pad_poller #(.NUM_PADS(1), .BITS_PER_PAD(16), .CLK_DIV(4), .POLL_PERIOD(50)) dut16 (
        .clk(clk), .rst(rst), .auto_poll(auto_poll16), .poll_req(poll_req16), .pad_data(pad_data16),
        .pad_latch(pad_latch16), .pad_clk(pad_clk16), .busy(busy16), .buttons(buttons16),
        .pressed(pressed16), .sample_valid(sample_valid16)
    );

    always #5 clk = ~clk;

    // pad model: latch presents bit 0, each shift-clock rising edge presents the next bit
    always @(posedge pad_latch or posedge pad_clk) cnt = pad_latch ? 0 : cnt + 1;
    always @(posedge pad_latch16 or posedge pad_clk16) cnt16 = pad_latch16 ? 0 : cnt16 + 1;

    always_comb begin
        for (int p = 0; p < 2; p++) pad_data[p] = glitch[p] ^ ~((cnt < 8) ? btn[p][cnt[2:0]] : 1'b0);
        pad_data16[0] = ~((cnt16 < 16) ? btn16[cnt16[3:0]] : 1'b0);
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    task automatic measure_poll(input bit glitch_en);
        int hi = 0, lo = 0;
        bit pc = 0, seen = 0;
        m_latch = 0; m_pulses = 0; m_badlen = 0; m_busy = 0; m_sv = 0; m_sv_at = 0;
        @(negedge clk) poll_req = 1;
        @(negedge clk) poll_req = 0;
        for (int i = 0; i < 400; i++) begin
            if (busy) begin seen = 1; m_busy++; end
            else if (seen) break;
            if (pad_latch) m_latch++;
            if (sample_valid) begin m_sv++; m_sv_at = m_busy; end
            if (pad_clk && !pc) begin m_pulses++; if (lo != 0 && lo != 4) m_badlen++; lo = 0; end
            if (!pad_clk && pc) begin if (hi != 4) m_badlen++; hi = 0; end
            if (pad_clk) hi++; else if (busy && !pad_latch) lo++;
            glitch = (glitch_en && ((pad_clk && !pc) || (pad_latch && m_latch == 1))) ? 2'b11 : 2'b00;
            pc = pad_clk;
            @(negedge clk);
        end
        glitch = '0;
        m_to = !(seen && !busy);
    endtask

    task automatic test_reset;
        rst = 1;
        repeat (3) @(negedge clk);
        rst = 0;
        @(negedge clk);
        checks++; if (pad_latch !== 1'b0) begin errors++; $display("FAIL reset_latch got %b exp 0", pad_latch); end
        checks++; if (pad_clk !== 1'b0) begin errors++; $display("FAIL reset_clk got %b exp 0", pad_clk); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b exp 0", busy); end
        checks++; if (sample_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %b exp 0", sample_valid); end
        checks++; if (buttons !== 16'h0) begin errors++; $display("FAIL reset_buttons got %h exp 0000", buttons); end
        checks++; if (pressed !== 16'h0) begin errors++; $display("FAIL reset_pressed got %h exp 0000", pressed); end
    endtask

    task automatic test_basic_poll;
        btn[0] = 8'h09;
        btn[1] = 8'h80;
        measure_poll(0);
        checks++; if (m_to !== 1'b0) begin errors++; $display("FAIL basic_timeout got %b exp 0", m_to); end
        checks++; if (m_latch != 8) begin errors++; $display("FAIL basic_latch_len got %0d exp 8", m_latch); end
        checks++; if (m_pulses != 7) begin errors++; $display("FAIL basic_clk_pulses got %0d exp 7", m_pulses); end
        checks++; if (m_badlen != 0) begin errors++; $display("FAIL basic_half_period got %0d bad exp 0", m_badlen); end
        checks++; if (m_busy != 65) begin errors++; $display("FAIL basic_busy_len got %0d exp 65", m_busy); end
        checks++; if (m_sv != 1) begin errors++; $display("FAIL basic_valid_count got %0d exp 1", m_sv); end
        checks++; if (m_sv_at != 65) begin errors++; $display("FAIL basic_valid_cycle got %0d exp 65", m_sv_at); end
        checks++; if (buttons !== 16'h8009) begin errors++; $display("FAIL basic_buttons got %h exp 8009", buttons); end
        checks++; if (pressed !== 16'h8009) begin errors++; $display("FAIL basic_pressed got %h exp 8009", pressed); end
        exp_prev = 16'h8009;
    endtask

    task automatic test_repeat;
        measure_poll(0);
        checks++; if (buttons !== 16'h8009) begin errors++; $display("FAIL repeat_buttons got %h exp 8009", buttons); end
        checks++; if (pressed !== 16'h0000) begin errors++; $display("FAIL repeat_pressed got %h exp 0000", pressed); end
    endtask

    task automatic test_random(input bit glitch_en);
        logic [15:0] want;
        for (int i = 0; i < 4; i++) begin
            btn[0] = 8'($urandom);
            btn[1] = 8'($urandom);
            want = {btn[1], btn[0]};
            measure_poll(glitch_en);
            checks++; if (m_to !== 1'b0) begin errors++; $display("FAIL rand_timeout g=%0d got %b exp 0", glitch_en, m_to); end
            checks++; if (buttons !== want) begin errors++; $display("FAIL rand_buttons g=%0d got %h exp %h", glitch_en, buttons, want); end
            checks++; if (pressed !== (want & ~exp_prev)) begin errors++; $display("FAIL rand_pressed g=%0d got %h exp %h", glitch_en, pressed, want & ~exp_prev); end
            exp_prev = want;
        end
    endtask

    task automatic test_auto;
        int starts[$];
        int svn = 0, bidx = 0;
        bit pb = 0;
        @(negedge clk) auto_poll = 1;
        for (int c = 0; c < 500; c++) begin
            if (busy && !pb) begin starts.push_back(c); bidx = 0; end
            if (busy) bidx++;
            poll_req = busy && bidx == 10;
            if (busy && bidx == 20 && starts.size() == 3) auto_poll = 0;
            if (sample_valid) svn++;
            pb = busy;
            @(negedge clk);
        end
        auto_poll = 0;
        poll_req = 0;
        checks++; if (starts.size() != 3) begin errors++; $display("FAIL auto_starts got %0d exp 3", starts.size()); end
        if (starts.size() >= 3) begin
            checks++; if (starts[1] - starts[0] != 100) begin errors++; $display("FAIL auto_period1 got %0d exp 100", starts[1] - starts[0]); end
            checks++; if (starts[2] - starts[1] != 100) begin errors++; $display("FAIL auto_period2 got %0d exp 100", starts[2] - starts[1]); end
        end
        checks++; if (svn != 3) begin errors++; $display("FAIL auto_valid_count got %0d exp 3", svn); end
    endtask

    task automatic test_reset_mid;
        logic [15:0] want;
        int svn = 0, bn = 0, k = 0;
        btn[0] = 8'h5A;
        btn[1] = 8'hA5;
        measure_poll(0);
        checks++; if (buttons !== 16'hA55A) begin errors++; $display("FAIL rmid_pre_buttons got %h exp a55a", buttons); end
        @(negedge clk) poll_req = 1;
        @(negedge clk) poll_req = 0;
        while (k < 30 && bn < 200) begin
            if (busy) k++;
            bn++;
            if (k < 30) @(negedge clk);
        end
        rst = 1;
        @(negedge clk);
        rst = 0;
        checks++; if (pad_latch !== 1'b0 || pad_clk !== 1'b0) begin errors++; $display("FAIL rmid_lines got %b%b exp 00", pad_latch, pad_clk); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rmid_busy got %b exp 0", busy); end
        checks++; if (buttons !== 16'h0) begin errors++; $display("FAIL rmid_buttons got %h exp 0000", buttons); end
        bn = 0;
        for (int c = 0; c < 150; c++) begin
            if (sample_valid) svn++;
            if (busy) bn++;
            @(negedge clk);
        end
        checks++; if (svn != 0) begin errors++; $display("FAIL rmid_valid got %0d exp 0", svn); end
        checks++; if (bn != 0) begin errors++; $display("FAIL rmid_spurious_busy got %0d exp 0", bn); end
        btn[0] = 8'($urandom);
        btn[1] = 8'($urandom);
        want = {btn[1], btn[0]};
        measure_poll(0);
        checks++; if (m_busy != 65) begin errors++; $display("FAIL rmid_busy_len got %0d exp 65", m_busy); end
        checks++; if (buttons !== want) begin errors++; $display("FAIL rmid_post_buttons got %h exp %h", buttons, want); end
        checks++; if (pressed !== want) begin errors++; $display("FAIL rmid_post_pressed got %h exp %h", pressed, want); end
        exp_prev = want;
    endtask

    task automatic test_snes_back_to_back;
        int rises[$], falls[$], pulses[$];
        int pc_n = 0;
        bit pb = 0, pc = 0;
        btn16 = 16'h0800;
        @(negedge clk) auto_poll16 = 1;
        for (int c = 0; c < 600; c++) begin
            if (busy16 && !pb) begin rises.push_back(c); pc_n = 0; end
            if (!busy16 && pb) begin falls.push_back(c); pulses.push_back(pc_n); end
            if (pad_clk16 && !pc) pc_n++;
            pb = busy16;
            pc = pad_clk16;
            @(negedge clk);
        end
        auto_poll16 = 0;
        checks++; if (rises.size() < 3 || falls.size() < 2) begin errors++; $display("FAIL snes_poll_count got %0d/%0d exp >=3/>=2", rises.size(), falls.size()); end
        if (rises.size() >= 3 && falls.size() >= 2) begin
            checks++; if (falls[1] - rises[1] != 129) begin errors++; $display("FAIL snes_busy_len got %0d exp 129", falls[1] - rises[1]); end
            checks++; if (rises[2] - falls[1] != 1) begin errors++; $display("FAIL snes_idle_gap got %0d exp 1", rises[2] - falls[1]); end
            checks++; if (pulses[1] != 15) begin errors++; $display("FAIL snes_clk_pulses got %0d exp 15", pulses[1]); end
        end
        repeat (140) @(negedge clk);
        checks++; if (buttons16 !== 16'h0800) begin errors++; $display("FAIL snes_buttons got %h exp 0800", buttons16); end
        checks++; if (pressed16 !== 16'h0000) begin errors++; $display("FAIL snes_pressed got %h exp 0000", pressed16); end
    endtask

    initial begin
        test_reset;
        test_basic_poll;
        test_repeat;
        test_random(0);
        test_random(1);
        test_auto;
        test_reset_mid;
        test_snes_back_to_back;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
